// File: rtl/quick_rs232_rx_ovs.sv
// Oversampling RS-232 receiver with run-time frame format, majority-vote sampling,
// a first-word-fall-through FIFO carrying per-byte error flags, and watermark-driven CTS.
module quick_rs232_rx_ovs #(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned CTS_THRESHOLD = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          cts,
    input  logic [1:0]                    cfg_byte_len,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop_bits,
    input  logic                          cfg_flow_control,
    input  logic                          rx_read,
    output logic                          rx_valid,
    output logic [7:0]                    rx_data,
    output logic                          rx_err_parity,
    output logic                          rx_err_frame,
    output logic                          rx_byte_received,
    output logic                          rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned OVS_DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned OVS_DIV     = (OVS_DIV_RAW < 1) ? 1 : OVS_DIV_RAW;
    localparam int unsigned OVS_W       = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam int unsigned SAMP_W      = $clog2(OVERSAMPLE);
    localparam int unsigned MID         = OVERSAMPLE / 2;
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W       = PTR_W + 1;
    localparam int unsigned ENTRY_W     = 10;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t               state;
    logic                 rx_meta, rx_s, rx_s_d;
    logic [OVS_W-1:0]     ovs_cnt;
    logic [SAMP_W-1:0]    samp_cnt;
    logic                 vote0, vote1;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
    logic [1:0]           byte_len_q, parity_q;
    logic                 stop2_q;
    logic                 par_err, frm_err;
    logic                 wr_req;
    logic [ENTRY_W-1:0]   wr_entry;

    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;

    logic                 rx_fall_c, restart_c, tick_c, decide_c, bit_c;
    logic                 parity_en_c, exp_par_c;
    logic [2:0]           last_idx_c;
    logic                 full_c, do_pop_c, do_wr_c;
    logic [CNT_W-1:0]     count_next_c;
    logic [PTR_W-1:0]     rd_ptr_next_c;
    logic [ENTRY_W-1:0]   head_next_c;

    always_comb begin
        rx_fall_c   = rx_s_d & ~rx_s;
        restart_c   = (state == S_IDLE) && rx_fall_c;
        tick_c      = (ovs_cnt == OVS_W'(OVS_DIV - 1));
        decide_c    = tick_c && (samp_cnt == SAMP_W'(MID + 1)) && (state != S_IDLE);
        bit_c       = (vote0 & vote1) | (vote0 & rx_s) | (vote1 & rx_s);
        parity_en_c = (parity_q == 2'd1) || (parity_q == 2'd2);
        exp_par_c   = (^shift) ^ (parity_q == 2'd1);
        last_idx_c  = 3'd4 + 3'(byte_len_q);
    end

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Oversample tick and per-bit sample position; realigned on every accepted start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovs_cnt  <= '0;
            samp_cnt <= '0;
            vote0    <= 1'b1;
            vote1    <= 1'b1;
        end else if (restart_c) begin
            ovs_cnt  <= '0;
            samp_cnt <= '0;
        end else begin
            ovs_cnt <= tick_c ? '0 : ovs_cnt + OVS_W'(1);
            if (tick_c) begin
                samp_cnt <= (samp_cnt == SAMP_W'(OVERSAMPLE - 1)) ? '0 : samp_cnt + SAMP_W'(1);
                if (samp_cnt == SAMP_W'(MID - 1)) vote0 <= rx_s;
                if (samp_cnt == SAMP_W'(MID))     vote1 <= rx_s;
            end
        end
    end

    // Frame FSM: state names the bit whose mid-bit decision is pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            bit_idx    <= '0;
            shift      <= '0;
            byte_len_q <= '0;
            parity_q   <= '0;
            stop2_q    <= 1'b0;
            par_err    <= 1'b0;
            frm_err    <= 1'b0;
            wr_req     <= 1'b0;
            wr_entry   <= '0;
        end else begin
            wr_req <= 1'b0;
            case (state)
                S_IDLE: if (rx_fall_c) begin
                    state      <= S_START;
                    byte_len_q <= cfg_byte_len;
                    parity_q   <= cfg_parity;
                    stop2_q    <= cfg_stop_bits;
                    shift      <= '0;
                    bit_idx    <= '0;
                    par_err    <= 1'b0;
                    frm_err    <= 1'b0;
                end
                S_START: if (decide_c) state <= bit_c ? S_IDLE : S_DATA;
                S_DATA: if (decide_c) begin
                    shift[bit_idx] <= bit_c;
                    if (bit_idx == last_idx_c) state <= parity_en_c ? S_PARITY : S_STOP1;
                    else                       bit_idx <= bit_idx + 3'd1;
                end
                S_PARITY: if (decide_c) begin
                    par_err <= (bit_c != exp_par_c);
                    state   <= S_STOP1;
                end
                S_STOP1, S_STOP2: if (decide_c) begin
                    frm_err <= frm_err | ~bit_c;
                    if (state == S_STOP1 && stop2_q) begin
                        state <= S_STOP2;
                    end else begin
                        state    <= S_IDLE;
                        wr_req   <= 1'b1;
                        wr_entry <= {frm_err | ~bit_c, par_err, shift};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping; head is forwarded from the write when it lands at the new read slot
    always_comb begin
        full_c        = (fifo_count == CNT_W'(FIFO_DEPTH));
        do_pop_c      = rx_read && (fifo_count != '0);
        do_wr_c       = wr_req && (!full_c || do_pop_c);
        count_next_c  = fifo_count + CNT_W'(do_wr_c) - CNT_W'(do_pop_c);
        rd_ptr_next_c = rd_ptr + PTR_W'(do_pop_c);
        if (count_next_c == '0)                     head_next_c = '0;
        else if (do_wr_c && wr_ptr == rd_ptr_next_c) head_next_c = wr_entry;
        else                                         head_next_c = mem[rd_ptr_next_c];
    end

    always_ff @(posedge clk) begin
        if (do_wr_c) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fifo_count       <= '0;
            rx_valid         <= 1'b0;
            rx_data          <= '0;
            rx_err_parity    <= 1'b0;
            rx_err_frame     <= 1'b0;
            rx_byte_received <= 1'b0;
            rx_overrun       <= 1'b0;
            cts              <= 1'b0;
        end else begin
            wr_ptr           <= wr_ptr + PTR_W'(do_wr_c);
            rd_ptr           <= rd_ptr_next_c;
            fifo_count       <= count_next_c;
            rx_valid         <= (count_next_c != '0);
            {rx_err_frame, rx_err_parity, rx_data} <= head_next_c;
            rx_byte_received <= do_wr_c;
            rx_overrun       <= wr_req && !do_wr_c;
            cts              <= cfg_flow_control ? (fifo_count < CNT_W'(CTS_THRESHOLD)) : 1'b1;
        end
    end

endmodule
